// File: rtl/riscv_ctrl_seq_if.sv
// Bus between the control sequencer and its instruction ROM / register-file datapath.
// The master side is the sequencer; the slave side is the ROM plus datapath.
interface riscv_ctrl_seq_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic [DATA_WIDTH-1:0]    instr_addr;
    logic [DATA_WIDTH-1:0]    instr;
    logic                     eq;
    logic [ADDRESS_WIDTH-1:0] rs1;
    logic [ADDRESS_WIDTH-1:0] rs2;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic                     RegWrite;
    logic                     ALUsrc;
    logic [2:0]               ALUCtrl;
    logic [DATA_WIDTH-1:0]    ImmOp;
    logic                     halted;

    modport master (
        output instr_addr, rs1, rs2, rd, RegWrite, ALUsrc, ALUCtrl, ImmOp, halted,
        input  instr, eq
    );

    modport slave (
        input  instr_addr, rs1, rs2, rd, RegWrite, ALUsrc, ALUCtrl, ImmOp, halted,
        output instr, eq
    );
endinterface

// File: rtl/riscv_ctrl_seq.sv
// Three-cycle FETCH/DECODE/EXEC control sequencer for a small RV32I subset.
// The control outputs are registered; they are loaded at the end of DECODE and cleared at the end of EXEC.
module riscv_ctrl_seq #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDRESS_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_PC      = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    riscv_ctrl_seq_if.master      bus
);
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    typedef struct packed {
        logic                     legal;
        logic                     beq;
        logic                     bne;
        logic [ADDRESS_WIDTH-1:0] rs1;
        logic [ADDRESS_WIDTH-1:0] rs2;
        logic [ADDRESS_WIDTH-1:0] rd;
        logic                     regwrite;
        logic                     alusrc;
        logic [2:0]               aluctrl;
        logic [DATA_WIDTH-1:0]    imm;
    } dec_t;

    localparam logic [DATA_WIDTH-1:0] PC_STEP = {{(DATA_WIDTH-3){1'b0}}, 3'b100};

    function automatic dec_t decode(input logic [DATA_WIDTH-1:0] i);
        dec_t d;
        d     = '0;
        d.rs1 = ADDRESS_WIDTH'(i[19:15]);
        case (i[6:0])
            7'b0010011: begin
                d.rd       = ADDRESS_WIDTH'(i[11:7]);
                d.regwrite = 1'b1;
                d.alusrc   = 1'b1;
                d.imm      = {{(DATA_WIDTH-12){i[31]}}, i[31:20]};
                case (i[14:12])
                    3'b000:  begin d.legal = 1'b1; d.aluctrl = 3'b000; end
                    3'b111:  begin d.legal = 1'b1; d.aluctrl = 3'b010; end
                    3'b110:  begin d.legal = 1'b1; d.aluctrl = 3'b011; end
                    default: d.legal = 1'b0;
                endcase
            end
            7'b0110011: begin
                d.rs2      = ADDRESS_WIDTH'(i[24:20]);
                d.rd       = ADDRESS_WIDTH'(i[11:7]);
                d.regwrite = 1'b1;
                case ({i[31:25], i[14:12]})
                    {7'b0000000, 3'b000}: begin d.legal = 1'b1; d.aluctrl = 3'b000; end
                    {7'b0100000, 3'b000}: begin d.legal = 1'b1; d.aluctrl = 3'b001; end
                    {7'b0000000, 3'b111}: begin d.legal = 1'b1; d.aluctrl = 3'b010; end
                    {7'b0000000, 3'b110}: begin d.legal = 1'b1; d.aluctrl = 3'b011; end
                    default:              d.legal = 1'b0;
                endcase
            end
            7'b1100011: begin
                d.rs2     = ADDRESS_WIDTH'(i[24:20]);
                d.aluctrl = 3'b001;
                d.imm     = {{(DATA_WIDTH-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                case (i[14:12])
                    3'b000:  begin d.legal = 1'b1; d.beq = 1'b1; end
                    3'b001:  begin d.legal = 1'b1; d.bne = 1'b1; end
                    default: d.legal = 1'b0;
                endcase
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    state_t                   state_r, state_s;
    dec_t                     dec_s;
    logic [DATA_WIDTH-1:0]    pc_r, pc_next_s;
    logic                     beq_r, bne_r, taken_s;
    logic                     halted_r;
    logic [ADDRESS_WIDTH-1:0] rs1_r, rs2_r, rd_r;
    logic                     regwrite_r, alusrc_r;
    logic [2:0]               aluctrl_r;
    logic [DATA_WIDTH-1:0]    imm_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, decode and branch resolution.
    always_comb begin
        state_s   = state_r;
        dec_s     = decode(bus.instr);
        taken_s   = (beq_r & bus.eq) | (bne_r & ~bus.eq);
        pc_next_s = pc_r + PC_STEP;
        if (taken_s) begin
            pc_next_s = pc_r + imm_r;
        end else begin
            pc_next_s = pc_r + PC_STEP;
        end
        if (en) begin
            case (state_r)
                ST_FETCH:  state_s = ST_DECODE;
                ST_DECODE: state_s = dec_s.legal ? ST_EXEC : ST_HALT;
                ST_EXEC:   state_s = ST_FETCH;
                ST_HALT:   state_s = ST_HALT;
                default:   state_s = ST_FETCH;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // PC, branch kind, halt flag and registered control outputs; all hold while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            beq_r      <= 1'b0;
            bne_r      <= 1'b0;
            halted_r   <= 1'b0;
            rs1_r      <= '0;
            rs2_r      <= '0;
            rd_r       <= '0;
            regwrite_r <= 1'b0;
            alusrc_r   <= 1'b0;
            aluctrl_r  <= 3'b000;
            imm_r      <= '0;
        end else if (en) begin
            case (state_r)
                ST_DECODE: begin
                    if (dec_s.legal) begin
                        beq_r      <= dec_s.beq;
                        bne_r      <= dec_s.bne;
                        rs1_r      <= dec_s.rs1;
                        rs2_r      <= dec_s.rs2;
                        rd_r       <= dec_s.rd;
                        regwrite_r <= dec_s.regwrite;
                        alusrc_r   <= dec_s.alusrc;
                        aluctrl_r  <= dec_s.aluctrl;
                        imm_r      <= dec_s.imm;
                    end else begin
                        halted_r   <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    pc_r       <= pc_next_s;
                    beq_r      <= 1'b0;
                    bne_r      <= 1'b0;
                    rs1_r      <= '0;
                    rs2_r      <= '0;
                    rd_r       <= '0;
                    regwrite_r <= 1'b0;
                    alusrc_r   <= 1'b0;
                    aluctrl_r  <= 3'b000;
                    imm_r      <= '0;
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end else begin
            pc_r <= pc_r;
        end
    end

    assign bus.instr_addr = pc_r;
    assign bus.rs1        = rs1_r;
    assign bus.rs2        = rs2_r;
    assign bus.rd         = rd_r;
    assign bus.RegWrite   = regwrite_r;
    assign bus.ALUsrc     = alusrc_r;
    assign bus.ALUCtrl    = aluctrl_r;
    assign bus.ImmOp      = imm_r;
    assign bus.halted     = halted_r;
endmodule

// File: tb/tb_riscv_ctrl_seq.sv
// Directed bench for riscv_ctrl_seq: synchronous ROM model, hand-computed control values.
module tb_riscv_ctrl_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] rom [0:15];

    riscv_ctrl_seq_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();

    riscv_ctrl_seq #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.instr <= rom[bus.instr_addr[5:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic src,
                       input logic [2:0] op, input logic [31:0] imm);
        chk({tag, ".rs1"}, 32'(bus.rs1), 32'(rs1));
        chk({tag, ".rs2"}, 32'(bus.rs2), 32'(rs2));
        chk({tag, ".rd"}, 32'(bus.rd), 32'(rd));
        chk({tag, ".RegWrite"}, 32'(bus.RegWrite), 32'(rw));
        chk({tag, ".ALUsrc"}, 32'(bus.ALUsrc), 32'(src));
        chk({tag, ".ALUCtrl"}, 32'(bus.ALUCtrl), 32'(op));
        chk({tag, ".ImmOp"}, bus.ImmOp, imm);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.eq = 1'b0;
        for (int k = 0; k < 16; k++) rom[k] = 32'h00000013;
        rom[0] = 32'h00500093;  // addi x1,x0,5
        rom[1] = 32'h402081B3;  // sub  x3,x1,x2
        rom[2] = 32'hFE009EE3;  // bne  x1,x0,-4
        rom[3] = 32'hFFF37293;  // andi x5,x6,-1
        rom[4] = 32'h009463B3;  // or   x7,x8,x9

        // reset state (cycle 0 after release)
        do_reset();
        chk("rst.addr", bus.instr_addr, 32'h0);
        chk("rst.halted", 32'(bus.halted), 32'h0);
        ctl("rst", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 32'h0);
        tick();
        chk("c1.RegWrite", 32'(bus.RegWrite), 32'h0);
        tick();
        ctl("addi", 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 3'b000, 32'h5);
        tick();
        chk("c3.addr", bus.instr_addr, 32'h4);
        ctl("c3", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 32'h0);
        tick(); tick();
        ctl("sub", 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 3'b001, 32'h0);
        tick(); tick(); tick();
        ctl("bne0", 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 3'b001, 32'hFFFFFFFC);
        tick();
        chk("bne0.target", bus.instr_addr, 32'h4);
        bus.eq = 1'b1;
        tick(); tick();
        ctl("sub2", 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 3'b001, 32'h0);
        tick(); tick(); tick();
        ctl("bne1", 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 3'b001, 32'hFFFFFFFC);
        tick();
        chk("bne1.fall", bus.instr_addr, 32'hC);
        bus.eq = 1'b0;
        tick(); tick();
        ctl("andi", 5'd6, 5'd0, 5'd5, 1'b1, 1'b1, 3'b010, 32'hFFFFFFFF);
        tick(); tick(); tick();
        ctl("or", 5'd8, 5'd9, 5'd7, 1'b1, 1'b0, 3'b011, 32'h0);

        // stall in EXEC of addi
        do_reset();
        tick(); tick();
        chk("stall.rw0", 32'(bus.RegWrite), 32'h1);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            ctl("stall", 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 3'b000, 32'h5);
            chk("stall.addr", bus.instr_addr, 32'h0);
        end
        en = 1'b1;
        tick();
        chk("stall.next", bus.instr_addr, 32'h4);
        chk("stall.rw_off", 32'(bus.RegWrite), 32'h0);

        // reset during a taken-branch EXEC
        rom[0] = 32'hFE009EE3;
        do_reset();
        tick(); tick();
        chk("rbr.imm", bus.ImmOp, 32'hFFFFFFFC);
        rst = 1'b1;
        tick();
        chk("rbr.addr", bus.instr_addr, 32'h0);
        chk("rbr.rw", 32'(bus.RegWrite), 32'h0);
        chk("rbr.imm0", bus.ImmOp, 32'h0);

        // illegal instruction -> HALT
        rom[0] = 32'h00000000;
        do_reset();
        tick();
        chk("ill.c1", 32'(bus.halted), 32'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("ill.halted", 32'(bus.halted), 32'h1);
            chk("ill.rw", 32'(bus.RegWrite), 32'h0);
            chk("ill.addr", bus.instr_addr, 32'h0);
        end
        rst = 1'b1;
        tick();
        chk("ill.rst", 32'(bus.halted), 32'h0);
        rom[0] = 32'h00500093;
        rst = 1'b0;
        tick(); tick();
        ctl("ill.recover", 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 3'b000, 32'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
